cla_pipe: RTL



---
 rtl/cla_pipe.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor. WIDTH/GROUP lookahead groups are spread
// evenly over STAGES register stages, LSB groups first; the last stage is the output register.
module cla_pipe #(
    parameter int WIDTH  = 8,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG  = WIDTH / GROUP;
    localparam int GPS = NG / STAGES;
    localparam int BPS = GPS * GROUP;

    // Handshake: a set enters when in_valid && in_ready, a result leaves when
    // out_valid && out_ready. The whole pipe (data and valid bits) freezes only while
    // the output holds an untaken result, so in_ready never depends on in_valid.
    logic stall;
    logic last_v;

    assign stall    = last_v && !out_ready;
    assign in_ready = !stall;

    // One lookahead block: returns {carry out, carry into top bit, sum bits}.
    function automatic logic [GROUP+1:0] cla_group(input logic [GROUP-1:0] x,
                                                   input logic [GROUP-1:0] y,
                                                   input logic             ci);
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] g;
        logic [GROUP:0]   c;
        logic             acc;
        logic             pp;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & ci);
        end
        return {c[GROUP], c[GROUP-1], p ^ c[GROUP-1:0]};
    endfunction

    for (genvar s = 0; s < STAGES; s++) begin : gen_stage
        logic [WIDTH-1:0] a_i, b_i, s_i;
        logic             c_i, v_i;
        logic [WIDTH-1:0] s_d;
        logic             c_d, m_d, carry;
        logic [GROUP+1:0] r;
        logic [WIDTH-1:0] a_q, b_q, s_q;
        logic             c_q, v_q;

        if (s == 0) begin : gen_head
            assign a_i = a;
            assign b_i = sub ? ~b : b;
            assign s_i = '0;
            assign c_i = cin ^ sub;
            assign v_i = in_valid;
        end else begin : gen_link
            assign a_i = gen_stage[s-1].a_q;
            assign b_i = gen_stage[s-1].b_q;
            assign s_i = gen_stage[s-1].s_q;
            assign c_i = gen_stage[s-1].c_q;
            assign v_i = gen_stage[s-1].v_q;
        end

        // Resolve this stage's slice of groups; the group carry chains LSB to MSB.
        always_comb begin
            s_d   = s_i;
            carry = c_i;
            m_d   = 1'b0;
            r     = '0;
            for (int k = 0; k < GPS; k++) begin
                r = cla_group(a_i[s*BPS + k*GROUP +: GROUP],
                              b_i[s*BPS + k*GROUP +: GROUP], carry);
                s_d[s*BPS + k*GROUP +: GROUP] = r[GROUP-1:0];
                m_d   = r[GROUP];
                carry = r[GROUP+1];
            end
            c_d = carry;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (!stall) begin
                a_q <= a_i;
                b_q <= b_i;
                s_q <= s_d;
                c_q <= c_d;
                v_q <= v_i;
            end
        end
    end

    logic ovf_q, zero_q;

    // Flags are formed as the MSB group resolves, so they register alongside sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (!stall) begin
            ovf_q  <= gen_stage[STAGES-1].m_d ^ gen_stage[STAGES-1].c_d;
            zero_q <= (gen_stage[STAGES-1].s_d == '0);
        end
    end

    assign last_v    = gen_stage[STAGES-1].v_q;
    assign out_valid = last_v;
    assign sum       = gen_stage[STAGES-1].s_q;
    assign cout      = gen_stage[STAGES-1].c_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
